// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default sizing.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_NREQ       = 4;
  localparam int unsigned DEF_BW         = 8;
  localparam int unsigned DEF_TIMEOUT    = 16;
  localparam int unsigned DEF_TIMER_BITS = 5;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the UART transmit arbiter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned BW   = DEF_BW
) ();

  localparam int unsigned OW = $clog2(NREQ);

  logic [NREQ-1:0]    in_req;
  logic [NREQ*BW-1:0] in_data;
  logic [NREQ-1:0]    in_lock;
  logic [NREQ-1:0]    out_grant;
  logic               out_tx_start;
  logic [BW-1:0]      out_tx_data;
  logic               in_tx_busy;
  logic [OW-1:0]      out_owner;
  logic               out_locked;
  logic               out_err;

  modport slave (
    input  in_req, in_data, in_lock, in_tx_busy,
    output out_grant, out_tx_start, out_tx_data, out_owner, out_locked, out_err
  );

  modport master (
    output in_req, in_data, in_lock, in_tx_busy,
    input  out_grant, out_tx_start, out_tx_data, out_owner, out_locked, out_err
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import uart_pkg::*;
#(
  parameter  int unsigned N  = DEF_NREQ,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  win_oh_o_c,
  output logic [IW-1:0] win_idx_o_c,
  output logic          any_o_c
);

  function automatic logic [IW-1:0] rot(input logic [IW-1:0] p, input int unsigned i);
    return IW'((32'(p) + i) % N);
  endfunction

  always_comb begin
    win_oh_o_c  = '0;
    win_idx_o_c = '0;
    any_o_c     = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_o_c && req_i[rot(ptr_i, i)]) begin
        any_o_c                     = 1'b1;
        win_idx_o_c                 = rot(ptr_i, i);
        win_oh_o_c[rot(ptr_i, i)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte producers with round-robin
// arbitration, optional multi-byte ownership lock and a launch timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ       = DEF_NREQ,
  parameter int unsigned BW         = DEF_BW,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned TIMER_BITS = DEF_TIMER_BITS
) (
  input logic              clk,
  input logic              i_reset_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned OW = $clog2(NREQ);

  arb_state_e            state_q, state_d;
  logic [TIMER_BITS-1:0] timer_q, timer_d;
  logic [OW-1:0]         ptr_q, ptr_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [NREQ-1:0]       grant_q, grant_d;
  logic                  start_q, start_d;
  logic [BW-1:0]         data_q, data_d;
  logic                  locked_q, locked_d;
  logic                  err_q, err_d;

  logic                  lock_hold;
  logic [NREQ-1:0]       pick_req;
  logic [NREQ-1:0]       pick_oh;
  logic [OW-1:0]         pick_idx;
  logic                  pick_any;
  logic [BW-1:0]         win_data;

  // While the owner keeps its lock, only its own request may compete.
  assign lock_hold = locked_q && bus.in_lock[owner_q];
  assign pick_req  = lock_hold ? (bus.in_req & (NREQ'(1) << owner_q)) : bus.in_req;

  rr_pick #(.N(NREQ)) u_pick (
    .req_i       (pick_req),
    .ptr_i       (ptr_q),
    .win_oh_o_c  (pick_oh),
    .win_idx_o_c (pick_idx),
    .any_o_c     (pick_any)
  );

  always_comb begin
    win_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (pick_idx == OW'(k)) win_data = bus.in_data[k*BW +: BW];
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      start_q  <= 1'b0;
      data_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      start_q  <= start_d;
      data_q   <= data_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    grant_d  = '0;
    start_d  = 1'b0;
    data_d   = data_q;
    locked_d = locked_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (locked_q && !lock_hold) locked_d = 1'b0;
        if (pick_any) begin
          grant_d = pick_oh;
          start_d = 1'b1;
          data_d  = win_data;
          owner_d = pick_idx;
          ptr_d   = (pick_idx == OW'(NREQ - 1)) ? '0 : pick_idx + OW'(1);
          timer_d = '0;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        // Busy already high at launch counts as the acknowledgement.
        if (bus.in_tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q == TIMER_BITS'(TIMEOUT - 1)) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          timer_d = timer_q + TIMER_BITS'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.in_tx_busy) begin
          locked_d = bus.in_lock[owner_q];
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.out_grant    = grant_q;
  assign bus.out_tx_start = start_q;
  assign bus.out_tx_data  = data_q;
  assign bus.out_owner    = owner_q;
  assign bus.out_locked   = locked_q;
  assign bus.out_err      = err_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single UART transmitter among `NREQ` byte producers, such as the receive echo path, the status reporter and the debug dump. Requests are arbitrated round-robin. A requester may lock the transmitter for a multi-byte message. The block launches one byte at a time into the transmitter with a start pulse and tracks the transmitter's busy line until the byte has left the line.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `BW`, 8: data bits per byte.
- `TIMEOUT`, 16: cycles allowed for `in_tx_busy` to rise after `out_tx_start`.
- `TIMER_BITS`, 5: width of the timeout counter; must hold `TIMEOUT`.
- `clk`  in  1  single clock.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `in_req`  in  NREQ  per-requester byte-valid; held until granted.
- `in_data`  in  NREQ*BW  requester k drives bits [k*BW +: BW].
- `in_lock`  in  NREQ  requester k asks to keep ownership after its current byte.
- `out_grant`  out  NREQ  one-hot, 1-cycle pulse; `in_data` slice consumed this cycle.
- `out_tx_start`  out  1  1-cycle launch pulse to the transmitter.
- `out_tx_data`  out  BW  byte for the transmitter; stable from launch until return to IDLE.
- `in_tx_busy`  in  1  transmitter busy, high while shifting.
- `out_owner`  out  $clog2(NREQ)  index of the last or current owner.
- `out_locked`  out  1  ownership held by `out_owner`.
- `out_err`  out  1  sticky; a launch timed out. Cleared only by reset.

## Operation
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- **IDLE, unlocked:**
  - Winner = first set bit of `in_req`, searching from priority pointer `ptr` upward with wrap modulo `NREQ`.
  - If a winner exists: pulse `out_grant[w]` and `out_tx_start`; latch `out_tx_data` <= slice w; `out_owner` <= w; `ptr` <= (w+1) mod NREQ; go to WAIT_BUSY.
- **IDLE, locked:**
  - Only `in_req[out_owner]` is considered; other requests wait.
  - If `in_lock[out_owner]` is low, unlock. On that same cycle, normal round-robin arbitration applies.
- **WAIT_BUSY:**
  - Timer counts up from 0.
  - `in_tx_busy` high -> WAIT_DONE.
  - Timer reaches `TIMEOUT`-1 without busy -> set `out_err`, clear lock, go to IDLE.
- **WAIT_DONE:**
  - `in_tx_busy` low -> IDLE.
  - On this exit, `out_locked` <= `in_lock[out_owner]`.
- The lock is sampled only at byte completion. The requester deasserting `in_lock` during a byte takes effect at that completion.
- `in_req` deasserted by the owner while locked: the block stays in IDLE, locked, and starves the others until the lock drops. This is intended.
- Requests and data are not registered. Requesters must hold them stable until granted.

## Timing
- **Reset values:**
  - `out_grant`=0, `out_tx_start`=0, `out_tx_data`=0, `out_owner`=0, `out_locked`=0, `out_err`=0.
  - `ptr`=0, state IDLE, timer 0.
- **Latency:** a request seen in IDLE at cycle t produces `out_grant`, `out_tx_start` and the registered `out_tx_data` in cycle t+1. All outputs are registered.
- **Back-to-back bytes:** a new launch occurs no earlier than 1 cycle after `in_tx_busy` is sampled low in WAIT_DONE (IDLE is visited for one cycle).
- **Busy already high at launch** (transmitter slow to drop): treated as the acknowledgement; goes to WAIT_DONE on the next cycle.
- **Simultaneous requests** are resolved purely by `ptr`. The lock request of a non-owner is ignored.
- **Reset mid-byte:** all state clears immediately. A transmitter already shifting is not aborted; the first post-reset launch waits until IDLE sees a request. The bench must drop `in_tx_busy` before expecting completion.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants (IDLE=0, WAIT_BUSY=1, WAIT_DONE=2);
  - default `BW`, `TIMEOUT`.
- Natural sub-module: `rr_pick`, a combinational round-robin priority picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot winner, index, any.
  - Reusable by a future RX FIFO drain scheduler.

## Test plan
- **Single request:** `in_req`=0001, data 0x41; transmitter model raises busy 2 cycles after start and holds it 10 cycles -> exactly one `out_grant`=0001 pulse; one `out_tx_start`; `out_tx_data`=0x41; `out_err` stays 0.
- **Round robin:** all four requesting continuously -> grant order 0,1,2,3,0; `ptr` wraps.
- **Lock:** requester 2 holds `in_lock` for 3 bytes (0x10, 0x11, 0x12) while requester 0 requests -> grants 2,2,2, then 0; `out_locked` falls after the third completion.
- **Timeout:** launch with busy never rising -> `out_err`=1 after `TIMEOUT` cycles; block returns to IDLE and the next request is still served.
- **Async reset:** assert `i_reset_n` low during WAIT_DONE with the lock held -> all outputs 0 without a clock edge; first post-reset grant goes to the lowest requesting index.
